pipe_stage_reg: RTL

Parametrised pipeline register that replaces the hand-written per-stage registers (MEM/WB first, then EX/MEM and ID/EX).
- Carries a control vector, a data vector and a valid bit from an upstream stage to a downstream stage.
- Supports stall-hold, bubble insertion and flush, with a per-bit control mask.
- Adds an optional forward-hold buffer. The buffer keeps the last retiring value for a consumer that forwards from this stage, so the downstream stage no longer has to stall merely to preserve forwarded data.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/pipe_hold_buf.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 86 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
// Each stage picks its control width and bubble mask from here.
// The field offsets let stage logic slice the packed data vector.
package pipe_pkg;

   // MEM/WB: ctrl = {RegWrite, MemtoReg}; data = {ReadData, ALU result, RtRd}
   localparam int              MEMWB_CTRL_W    = 2;
   localparam logic [1:0]      MEMWB_CTRL_MASK = 2'b10;
   localparam int              MEMWB_RTRD_LSB  = 0;
   localparam int              MEMWB_RTRD_W    = 5;
   localparam int              MEMWB_ALU_LSB   = 5;
   localparam int              MEMWB_ALU_W     = 32;
   localparam int              MEMWB_RDATA_LSB = 37;
   localparam int              MEMWB_RDATA_W   = 32;
   localparam int              MEMWB_DATA_W    = 69;

   // EX/MEM: ctrl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
   // MemtoReg only steers a mux, so it is allowed to pass through a bubble.
   localparam int              EXMEM_CTRL_W    = 5;
   localparam logic [4:0]      EXMEM_CTRL_MASK = 5'b10111;
   localparam int              EXMEM_RTRD_LSB  = 0;
   localparam int              EXMEM_RTRD_W    = 5;
   localparam int              EXMEM_WDATA_LSB = 5;
   localparam int              EXMEM_WDATA_W   = 32;
   localparam int              EXMEM_ALU_LSB   = 37;
   localparam int              EXMEM_ALU_W     = 32;
   localparam int              EXMEM_DATA_W    = 69;

   // ID/EX: ctrl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite,
   //                RegDst, ALUOp[1:0], ALUSrc}
   // Only the bits with architectural side effects are cleared on a bubble.
   localparam int              IDEX_CTRL_W     = 9;
   localparam logic [8:0]      IDEX_CTRL_MASK  = 9'b1_0111_0000;
   localparam int              IDEX_RD_LSB     = 0;
   localparam int              IDEX_RD_W       = 5;
   localparam int              IDEX_RT_LSB     = 5;
   localparam int              IDEX_RT_W       = 5;
   localparam int              IDEX_RS_LSB     = 10;
   localparam int              IDEX_RS_W       = 5;
   localparam int              IDEX_IMM_LSB    = 15;
   localparam int              IDEX_IMM_W      = 32;
   localparam int              IDEX_RDATA2_LSB = 47;
   localparam int              IDEX_RDATA2_W   = 32;
   localparam int              IDEX_RDATA1_LSB = 79;
   localparam int              IDEX_RDATA1_W   = 32;
   localparam int              IDEX_DATA_W     = 111;

endpackage

// File: rtl/pipe_hold_buf.sv
// Single-entry forward-hold buffer.
// Keeps a copy of the stage output that is about to be overwritten so a
// forwarding consumer can still read it after the stage advances.
module pipe_hold_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = MEMWB_DATA_W,
   parameter int CTRL_W = MEMWB_CTRL_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              advance,
   input  logic              hold_req,
   input  logic              hold_clear,
   input  logic              cur_valid,
   input  logic [CTRL_W-1:0] cur_ctrl,
   input  logic [DATA_W-1:0] cur_data,
   output logic              hold_valid,
   output logic [CTRL_W-1:0] hold_ctrl,
   output logic [DATA_W-1:0] hold_data
);

   logic capture;

   // A capture may replace the entry only when it is empty or being released.
   always_comb begin
      capture = advance & hold_req & cur_valid & (~hold_valid | hold_clear);
   end

   // Capture the retiring value, or release the entry; contents stay put on release.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_ctrl  <= '0;
         hold_data  <= '0;
      end else if (capture) begin
         hold_valid <= 1'b1;
         hold_ctrl  <= cur_ctrl;
         hold_data  <= cur_data;
      end else if (hold_clear) begin
         hold_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between two stages.
// Handles downstream stall (hold), upstream stall/flush (bubble with masked
// control, data still loaded) and an optional forward-hold buffer.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = MEMWB_DATA_W,
   parameter int                CTRL_W    = MEMWB_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_MASK = {CTRL_W{1'b1}},
   parameter int                FWD_HOLD  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              up_stall,
   input  logic              up_flush,
   input  logic              dn_stall,
   input  logic              in_valid,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              hold_req,
   input  logic              hold_clear,
   output logic              hold_valid,
   output logic [CTRL_W-1:0] hold_ctrl,
   output logic [DATA_W-1:0] hold_data
);

   logic advance;

   // The stage moves forward on any edge that is neither reset nor held downstream.
   always_comb begin
      advance = ~reset & ~dn_stall;
   end

   // Main register: reset, then downstream hold, then bubble, then normal load.
   // Data is loaded even on a bubble so exception state survives a flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (dn_stall) begin
         out_valid <= out_valid;
         out_ctrl  <= out_ctrl;
         out_data  <= out_data;
      end else if (up_stall | up_flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= in_ctrl & ~CTRL_MASK;
         out_data  <= in_data;
      end else begin
         out_valid <= in_valid;
         out_ctrl  <= in_ctrl;
         out_data  <= in_data;
      end
   end

   generate
      if (FWD_HOLD != 0) begin : g_hold
         pipe_hold_buf #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_hold_buf (
            .clock      (clock),
            .reset      (reset),
            .advance    (advance),
            .hold_req   (hold_req),
            .hold_clear (hold_clear),
            .cur_valid  (out_valid),
            .cur_ctrl   (out_ctrl),
            .cur_data   (out_data),
            .hold_valid (hold_valid),
            .hold_ctrl  (hold_ctrl),
            .hold_data  (hold_data)
         );
      end else begin : g_no_hold
         logic hold_unused;
         assign hold_unused = hold_req ^ hold_clear ^ advance;
         assign hold_valid  = 1'b0;
         assign hold_ctrl   = '0;
         assign hold_data   = '0;
      end
   endgenerate

endmodule
